countdown_timer: RTL and testbench

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

---
 rtl/countdown_timer.sv | 100 ++++++++++
 tb/tb_countdown_timer.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/countdown_timer.sv
// Seconds countdown with free-running prescaler and 1 Hz / 2 Hz strobes.
// A rising edge on start_timer (re)loads the count; expired latches at zero.
module countdown_timer #(
   parameter int CLK_HZ = 50000000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       start_timer,
   input  logic [3:0] value,
   output logic       expired,
   output logic       one_hz_enable,
   output logic       two_hz_enable,
   output logic       busy,
   output logic [3:0] remaining
);

   localparam int PW = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
   localparam logic [PW-1:0] LAST = PW'(CLK_HZ - 1);
   localparam logic [PW-1:0] HALF = PW'(CLK_HZ / 2 - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COUNT   = 2'd1,
      EXPIRED = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [3:0]    rem_q, rem_d;
   logic          exp_q, exp_d;
   logic          start_q;
   logic          start_evt;
   logic          tick;

   assign tick      = (presc_q == LAST);
   assign start_evt = start_timer & ~start_q;

   assign one_hz_enable = tick;
   assign two_hz_enable = tick | (presc_q == HALF);
   assign busy          = (state_q == COUNT);
   assign remaining     = rem_q;
   assign expired       = exp_q;

   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      exp_d   = exp_q;
      presc_d = tick ? '0 : presc_q + 1'b1;
      if (start_evt) begin
         // A start always wins over a coincident tick.
         presc_d = '0;
         rem_d   = value;
         exp_d   = 1'b0;
         state_d = (value != 4'd0) ? COUNT : EXPIRED;
      end else begin
         unique case (state_q)
            IDLE: begin
               exp_d = 1'b0;
            end
            COUNT: begin
               if (tick) begin
                  if (rem_q <= 4'd1) begin
                     state_d = EXPIRED;
                     rem_d   = 4'd0;
                     exp_d   = 1'b1;
                  end else begin
                     rem_d = rem_q - 4'd1;
                  end
               end
            end
            EXPIRED: begin
               rem_d = 4'd0;
               exp_d = 1'b1;
            end
            default: begin
               state_d = IDLE;
               rem_d   = 4'd0;
               exp_d   = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         presc_q <= '0;
         rem_q   <= 4'd0;
         exp_q   <= 1'b0;
         start_q <= 1'b0;
      end else begin
         state_q <= state_d;
         presc_q <= presc_d;
         rem_q   <= rem_d;
         exp_q   <= exp_d;
         start_q <= start_timer;
      end
   end

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer at CLK_HZ = 8.
// Inputs change and outputs are sampled on the falling edge.
module tb_countdown_timer;

   logic       clock;
   logic       reset;
   logic       start_timer;
   logic [3:0] value;
   logic       expired;
   logic       one_hz_enable;
   logic       two_hz_enable;
   logic       busy;
   logic [3:0] remaining;

   int vecs = 0;
   int errs = 0;

   countdown_timer #(.CLK_HZ(8)) dut (
      .clock         (clock),
      .reset         (reset),
      .start_timer   (start_timer),
      .value         (value),
      .expired       (expired),
      .one_hz_enable (one_hz_enable),
      .two_hz_enable (two_hz_enable),
      .busy          (busy),
      .remaining     (remaining)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [3:0] obs,
                      input logic [3:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic adv(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic chk_all(input string tag, input logic b, input logic e,
                          input logic [3:0] r);
      chk({tag, ".busy"}, {3'b0, busy}, {3'b0, b});
      chk({tag, ".expired"}, {3'b0, expired}, {3'b0, e});
      chk({tag, ".remaining"}, remaining, r);
   endtask

   initial begin
      reset       = 1'b1;
      start_timer = 1'b0;
      value       = 4'd0;

      // reset state
      adv(2);
      chk_all("rst", 1'b0, 1'b0, 4'd0);
      chk("rst.one_hz", {3'b0, one_hz_enable}, 4'd0);
      chk("rst.two_hz", {3'b0, two_hz_enable}, 4'd0);

      // free run: prescaler is i mod 8 after i edges past reset
      reset = 1'b0;
      for (int i = 1; i <= 16; i++) begin
         adv(1);
         chk($sformatf("free%0d.one_hz", i), {3'b0, one_hz_enable},
             {3'b0, (i % 8) == 7});
         chk($sformatf("free%0d.two_hz", i), {3'b0, two_hz_enable},
             {3'b0, ((i % 8) == 7) || ((i % 8) == 3)});
      end

      // value=3 countdown
      start_timer = 1'b1;
      value       = 4'd3;
      adv(1);
      chk_all("v3.k", 1'b1, 1'b0, 4'd3);
      start_timer = 1'b0;
      value       = 4'd7;
      adv(7);
      chk_all("v3.k7", 1'b1, 1'b0, 4'd3);
      chk("v3.k7.one_hz", {3'b0, one_hz_enable}, 4'd1);
      adv(1);
      chk_all("v3.k8", 1'b1, 1'b0, 4'd2);
      adv(8);
      chk_all("v3.k16", 1'b1, 1'b0, 4'd1);
      adv(7);
      chk_all("v3.k23", 1'b1, 1'b0, 4'd1);
      adv(1);
      chk_all("v3.k24", 1'b0, 1'b1, 4'd0);
      adv(16);
      chk_all("v3.k40", 1'b0, 1'b1, 4'd0);

      // value=0 from EXPIRED: start clears expired, re-asserts next cycle
      start_timer = 1'b1;
      value       = 4'd0;
      adv(1);
      chk_all("v0.k", 1'b0, 1'b0, 4'd0);
      adv(1);
      chk_all("v0.k1", 1'b0, 1'b1, 4'd0);
      start_timer = 1'b0;
      adv(1);

      // value=5, restarted with value=2 at k+12
      start_timer = 1'b1;
      value       = 4'd5;
      adv(1);
      chk_all("v5.k", 1'b1, 1'b0, 4'd5);
      start_timer = 1'b0;
      adv(11);
      chk_all("v5.k11", 1'b1, 1'b0, 4'd4);
      start_timer = 1'b1;
      value       = 4'd2;
      adv(1);
      chk_all("v5.k12", 1'b1, 1'b0, 4'd2);
      start_timer = 1'b0;
      adv(8);
      chk_all("v5.k20", 1'b1, 1'b0, 4'd1);
      adv(7);
      chk_all("v5.k27", 1'b1, 1'b0, 4'd1);
      adv(1);
      chk_all("v5.k28", 1'b0, 1'b1, 4'd0);
      adv(12);
      chk_all("v5.k40", 1'b0, 1'b1, 4'd0);

      // value=4, reset at k+10 abandons count
      start_timer = 1'b1;
      value       = 4'd4;
      adv(1);
      chk_all("v4.k", 1'b1, 1'b0, 4'd4);
      start_timer = 1'b0;
      adv(9);
      reset = 1'b1;
      adv(1);
      chk_all("v4.rst", 1'b0, 1'b0, 4'd0);
      chk("v4.rst.two_hz", {3'b0, two_hz_enable}, 4'd0);
      reset = 1'b0;
      adv(40);
      chk_all("v4.after", 1'b0, 1'b0, 4'd0);

      // held start, value changed mid-count
      start_timer = 1'b1;
      value       = 4'd2;
      adv(1);
      chk_all("hold.k", 1'b1, 1'b0, 4'd2);
      adv(2);
      value = 4'd9;
      adv(13);
      chk_all("hold.k15", 1'b1, 1'b0, 4'd1);
      adv(1);
      chk_all("hold.k16", 1'b0, 1'b1, 4'd0);
      adv(24);
      chk_all("hold.k40", 1'b0, 1'b1, 4'd0);

      // reset overrides start; start held across release counts
      reset = 1'b1;
      value = 4'd3;
      adv(1);
      chk_all("rs.rst", 1'b0, 1'b0, 4'd0);
      reset = 1'b0;
      adv(1);
      chk_all("rs.j", 1'b1, 1'b0, 4'd3);
      start_timer = 1'b0;
      adv(7);
      chk("rs.j7.one_hz", {3'b0, one_hz_enable}, 4'd1);

      // start coincident with tick wins
      start_timer = 1'b1;
      value       = 4'd6;
      adv(1);
      chk_all("rs.j8", 1'b1, 1'b0, 4'd6);
      chk("rs.j8.one_hz", {3'b0, one_hz_enable}, 4'd0);
      start_timer = 1'b0;
      adv(1);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
